// File: rtl/vector_dispatch_pkg.sv
// Shared types, constants and the grant-search helper for vector_dispatch.
// Index width covers the largest supported channel count (64).
package vector_dispatch_pkg;

    localparam int          MAX_CHAN = 64;
    localparam int          CHAN_W   = 6;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef logic [CHAN_W-1:0] chan_t;
    typedef logic [CHAN_W:0]   chan_cnt_t;

    typedef struct packed {
        logic  found;
        chan_t idx;
    } grant_t;

    // First set bit of vec[0 +: n] scanning upward from off and wrapping at n.
    // The loop runs high-to-low so the closest candidate to off is written last.
    function automatic grant_t first_set_from(input logic [MAX_CHAN-1:0] vec,
                                              input chan_t               off,
                                              input chan_cnt_t           n);
        grant_t    res;
        chan_cnt_t idx;
        res = '0;
        for (int i = MAX_CHAN - 1; i >= 0; i--) begin
            idx = {1'b0, off} + chan_cnt_t'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((chan_cnt_t'(i) < n) && vec[idx[CHAN_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[CHAN_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vector_dispatch_fifo.sv
// Single-channel FIFO for vector_dispatch: extra pointer bit separates full from empty.
// Storage is not reset; only the pointers are.
module dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq,
    input  logic [DW-1:0] din,
    input  logic          deq,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_enq;
    logic          do_deq;

    assign full   = (wr_ptr ^ rd_ptr) == ptr_t'(DEPTH);
    assign empty  = (wr_ptr == rd_ptr);
    assign do_enq = enq & ~full;
    assign do_deq = deq & ~empty;
    assign head   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_deq) rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/vector_dispatch.sv
// N-channel message dispatcher: say(meth,v) queues into FIFO[meth], one heard() port drains them.
// Define VECTOR_DISPATCH_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module vector_dispatch
    import vector_dispatch_pkg::*;
#(
    parameter int NCHAN = 10,
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          say__ENA,
    input  logic [31:0]   say_meth,
    input  logic [DW-1:0] say_v,
    output logic          say__RDY,
    output logic          ind_heard__ENA,
    output logic [31:0]   ind_heard_heard_meth,
    output logic [DW-1:0] ind_heard_heard_v,
    input  logic          ind_heard__RDY,
    output logic          err_badmeth,
    output logic [15:0]   drop_count
);

    logic             in_range;
    logic             sel_full;
    logic             accept;
    logic [NCHAN-1:0] enq;
    logic [NCHAN-1:0] deq;
    logic [NCHAN-1:0] full;
    logic [NCHAN-1:0] empty;
    logic [DW-1:0]    head [NCHAN];
    logic [DW-1:0]    head_sel;
    chan_t            scan_off;
    grant_t           search;
    chan_t            grant;
    chan_t            lock_gnt;
    logic             lock;
    logic             ena;
    logic             xfer;

    // Request side: readiness depends only on the addressed channel's fullness.
    assign in_range = (say_meth < 32'(NCHAN));

    always_comb begin
        sel_full = 1'b0;
        for (int c = 0; c < NCHAN; c++) begin
            if (say_meth == 32'(c)) sel_full = full[c];
        end
    end

    assign say__RDY = ~in_range | ~sel_full;
    assign accept   = say__ENA & say__RDY;

    always_comb begin
        enq = '0;
        for (int c = 0; c < NCHAN; c++) begin
            enq[c] = accept & (say_meth == 32'(c));
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        dispatch_fifo #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_fifo (
            .clk   (CLK),
            .rst_n (nRST),
            .enq   (enq[g]),
            .din   (say_v),
            .deq   (deq[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head[g])
        );
    end

`ifdef VECTOR_DISPATCH_RR_EN
    chan_t rr_ptr;

    assign scan_off = rr_ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (grant == chan_t'(NCHAN - 1)) ? '0 : grant + chan_t'(1);
        end
    end
`else
    assign scan_off = '0;
`endif

    // Arbitration: a stalled indication keeps its channel until it transfers.
    assign search = first_set_from(MAX_CHAN'(~empty), scan_off, chan_cnt_t'(NCHAN));
    assign ena    = search.found;
    assign grant  = lock ? lock_gnt : search.idx;
    assign xfer   = ena & ind_heard__RDY;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lock     <= 1'b0;
            lock_gnt <= '0;
        end else if (xfer) begin
            lock     <= 1'b0;
        end else if (ena) begin
            lock     <= 1'b1;
            lock_gnt <= grant;
        end
    end

    always_comb begin
        head_sel = '0;
        deq      = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (grant == chan_t'(c)) begin
                head_sel = head[c];
                deq[c]   = xfer;
            end
        end
    end

    assign ind_heard__ENA       = ena;
    assign ind_heard_heard_meth = ena ? 32'(grant) : 32'd0;
    assign ind_heard_heard_v    = ena ? head_sel : '0;

    // Out-of-range requests are swallowed and accounted for here.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_badmeth <= 1'b0;
            drop_count  <= '0;
        end else if (say__ENA && !in_range) begin
            err_badmeth <= 1'b1;
            if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
